// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg: shared constants for the multi-entry skid buffer.
// Build option: define SKID_BUFFER_BYPASS_EN for the zero-latency empty-buffer path.
package skid_buffer_pkg;

    // Default payload width in bits.
    localparam int SKID_DEFAULT_DATA_W = 32;

    // Default number of storage entries (power of two, at least 2).
    localparam int SKID_DEFAULT_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_if.sv
// skid_buffer_if: valid/ready stream bundle around the skid buffer.
// The slave modport is the buffer's view; the master modport is the
// producer/consumer side that surrounds it.
interface skid_buffer_if
    import skid_buffer_pkg::*;
#(
    parameter int DATA_W = SKID_DEFAULT_DATA_W,
    parameter int DEPTH  = SKID_DEFAULT_DEPTH
);

    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_data;
    logic                         in_transfer;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    logic                         out_transfer;
    logic                         enable_transfer;
    logic                         flush;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  enable_transfer,
        input  flush,
        output in_ready,
        output in_transfer,
        output out_valid,
        output out_data,
        output out_transfer,
        output level
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output enable_transfer,
        output flush,
        input  in_ready,
        input  in_transfer,
        input  out_valid,
        input  out_data,
        input  out_transfer,
        input  level
    );

endinterface

// File: rtl/skid_buffer_mem.sv
// skid_buffer_mem: DEPTH x DATA_W register array, one synchronous write
// port and one asynchronous read port. Data storage carries no reset since
// contents of empty entries are never observed.
module skid_buffer_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Capture the incoming word into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: parametrised multi-entry skid buffer for Versat unit streams.
// in_ready depends only on registered occupancy (plus flush/rst), so the
// consumer's out_ready never reaches the producer combinationally.
// enable_transfer lets the owning unit stall the output side without loss.
// Build option: SKID_BUFFER_BYPASS_EN -- when empty and not flushing, the
// input word is presented directly at the output (zero latency); if it is
// consumed in that same cycle it is never stored.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int DATA_W = SKID_DEFAULT_DATA_W,
    parameter int DEPTH  = SKID_DEFAULT_DEPTH
) (
    input logic          clk,
    input logic          rst,
    skid_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [LVL_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] out_data_s;
    logic              full_s;
    logic              empty_s;
    logic              in_ready_s;
    logic              in_xfer_s;
    logic              out_valid_s;
    logic              out_xfer_s;
    logic              bypass_s;
    logic              store_s;
    logic              retire_s;

    assign full_s  = (count_r == FULL_LVL);
    assign empty_s = (count_r == LVL_W'(0));

    // Choose between the stored head and, in bypass builds, the live input.
    always_comb begin
        bypass_s = 1'b0;
`ifdef SKID_BUFFER_BYPASS_EN
        bypass_s = empty_s && !bus.flush && !rst;
`endif
        if (bypass_s) begin
            out_valid_s = bus.in_valid;
            out_data_s  = bus.in_data;
        end else begin
            out_valid_s = !empty_s && !rst;
            out_data_s  = rd_data_s;
        end
    end

    assign in_ready_s = !full_s && !bus.flush && !rst;
    assign in_xfer_s  = bus.in_valid && in_ready_s;
    assign out_xfer_s = out_valid_s && bus.out_ready && bus.enable_transfer;

    // A word that passes straight through is neither stored nor retired.
    assign store_s  = in_xfer_s && !(bypass_s && out_xfer_s);
    assign retire_s = out_xfer_s && !bypass_s;

    assign bus.in_ready     = in_ready_s;
    assign bus.in_transfer  = in_xfer_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_data     = out_data_s;
    assign bus.out_transfer = out_xfer_s;
    assign bus.level        = rst ? LVL_W'(0) : count_r;

    // Occupancy and pointer bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= LVL_W'(0);
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else if (bus.flush) begin
            count_r  <= LVL_W'(0);
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({store_s, retire_s})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    skid_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (store_s),
        .waddr (wr_ptr_r),
        .wdata (bus.in_data),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed stimulus with a queue-based scoreboard.
// Accepted input words are queued; a negedge monitor compares every
// handshake output and the head word against the bench's own model.
module tb_skid_buffer;

    localparam int DW  = 32;
    localparam int DEP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   rx_cnt;

    logic [DW-1:0] exp_q [$];

    skid_buffer_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

    skid_buffer #(
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reference model of occupancy plus scoreboard of stored words.
    initial begin
        logic          e_ir;
        logic          e_ov;
        logic          e_it;
        logic          e_ot;
        logic          byp;
        logic [DW-1:0] e_od;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
                check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
                check("rst_level", {61'd0, bus.level}, 64'd0);
                check("rst_in_transfer", {63'd0, bus.in_transfer}, 64'd0);
                check("rst_out_transfer", {63'd0, bus.out_transfer}, 64'd0);
                exp_q.delete();
            end else begin
                byp = 1'b0;
`ifdef SKID_BUFFER_BYPASS_EN
                byp = (exp_q.size() == 0) && !bus.flush;
`endif
                e_ir = (exp_q.size() != DEP) && !bus.flush;
                e_ov = byp ? bus.in_valid : (exp_q.size() != 0);
                e_od = byp ? bus.in_data : ((exp_q.size() != 0) ? exp_q[0] : 32'd0);
                e_it = bus.in_valid && e_ir;
                e_ot = e_ov && bus.out_ready && bus.enable_transfer;
                check("in_ready", {63'd0, bus.in_ready}, {63'd0, e_ir});
                check("out_valid", {63'd0, bus.out_valid}, {63'd0, e_ov});
                check("level", {61'd0, bus.level}, 64'(exp_q.size()));
                check("in_transfer", {63'd0, bus.in_transfer}, {63'd0, e_it});
                check("out_transfer", {63'd0, bus.out_transfer}, {63'd0, e_ot});
                if (e_ov) begin
                    check("out_data", {32'd0, bus.out_data}, {32'd0, e_od});
                end
                if (bus.out_transfer) begin
                    rx_cnt++;
                end
                if (bus.flush) begin
                    exp_q.delete();
                end else if (!(byp && e_ot)) begin
                    if (e_it) begin
                        exp_q.push_back(bus.in_data);
                    end
                    if (e_ot) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        checks              = 0;
        failures            = 0;
        rx_cnt              = 0;
        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_data         = 32'd0;
        bus.out_ready       = 1'b0;
        bus.enable_transfer = 1'b1;
        bus.flush           = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("release_level", {61'd0, bus.level}, 64'd0);

        // Fill to DEPTH with the consumer stalled, then drain in order.
        for (int i = 0; i < DEP; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA0 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("fill_level", {61'd0, bus.level}, 64'd4);
        check("fill_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("fill_head", {32'd0, bus.out_data}, 64'hA0);
        bus.out_ready = 1'b1;
        step();
        check("first_pop_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("first_pop_head", {32'd0, bus.out_data}, 64'hA1);
        repeat (3) step();
        bus.out_ready = 1'b0;
        check("drain_level", {61'd0, bus.level}, 64'd0);

        // Streaming: 100 incrementing words, push and pop every cycle.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus.in_data = 32'h100 + 32'(k);
            step();
            check("stream_level_le1", {63'd0, (bus.level <= 3'd1)}, 64'd1);
        end
        bus.in_valid = 1'b0;
        for (int n = 0; n < 8 && bus.level != 3'd0; n++) begin
            step();
        end
        check("stream_drained", {61'd0, bus.level}, 64'd0);
        bus.out_ready = 1'b0;

        // Enable gate: level 2, consumer ready but unit stalls the output.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hB0;
        step();
        bus.in_data  = 32'hB1;
        step();
        bus.in_valid        = 1'b0;
        bus.enable_transfer = 1'b0;
        bus.out_ready       = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("gate_out_transfer", {63'd0, bus.out_transfer}, 64'd0);
            check("gate_out_data", {32'd0, bus.out_data}, 64'hB0);
            step();
            check("gate_level", {61'd0, bus.level}, 64'd2);
        end
        bus.enable_transfer = 1'b1;
        step();
        step();
        check("gate_after_level", {61'd0, bus.level}, 64'd0);
        bus.out_ready = 1'b0;

        // Flush at level 3 with a concurrent incoming word.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC0 + 32'(i);
            step();
        end
        bus.in_data = 32'hCF;
        bus.flush   = 1'b1;
        #1;
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_level", {61'd0, bus.level}, 64'd0);
        check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("flush_no_store", {61'd0, bus.level}, 64'd0);

        // Flush with a pop in the same cycle: head D0 still delivered.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hD0;
        step();
        bus.in_data  = 32'hD1;
        step();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("flush_pop_transfer", {63'd0, bus.out_transfer}, 64'd1);
        check("flush_pop_data", {32'd0, bus.out_data}, 64'hD0);
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("flush_pop_level", {61'd0, bus.level}, 64'd0);

        // Reset mid-stream at level 2.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hE0;
        step();
        bus.in_data  = 32'hE1;
        step();
        bus.in_data = 32'hEE;
        rst         = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_rel_level", {61'd0, bus.level}, 64'd0);
        check("midrst_rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();

        // Wrap-around: 7 alternating push/pop pairs with data 1..7.
        for (int i = 1; i <= 7; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(i);
            bus.out_ready = 1'b0;
            step();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            check("wrap_data", {32'd0, bus.out_data}, 64'(i));
            step();
        end
        bus.out_ready = 1'b0;
        check("wrap_level", {61'd0, bus.level}, 64'd0);

        // Total delivered: fill 4 + stream 100 + gate 2 + flush-pop 1 + wrap 7.
        step();
        check("rx_total", 64'(rx_cnt), 64'd114);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skid_buffer.md
# skid_buffer

Parametrised multi-entry skid buffer with datapath for Versat unit interfaces. It generalises the single-slot skid controller to DATA_W-bit payload storage, DEPTH entries, a synchronous flush and an occupancy output. It sits between a producer and consumer on a valid/ready stream, breaking the combinational ready path so `in_ready` never depends on same-cycle `out_ready`. The `enable_transfer` gate is kept so a unit can stall its output without losing data.

## Interface
- `DATA_W`, 32: payload width in bits, ≥1.
- `DEPTH`, 2: number of storage entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  buffer can accept; a function of registered state only.
- `in_data`  in  DATA_W  producer payload.
- `in_transfer`  out  1  `in_valid && in_ready`.
- `out_valid`  out  1  buffer presents data.
- `out_ready`  in  1  consumer can accept.
- `out_data`  out  DATA_W  head payload.
- `out_transfer`  out  1  `out_valid && out_ready && enable_transfer`.
- `enable_transfer`  in  1  unit permits output transfer; when low, no pop occurs.
- `flush`  in  1  synchronous discard of all stored entries.
- `level`  out  $clog2(DEPTH+1)  current entry count.

## Operation
- State: `count` (0..DEPTH), `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits and wrapping modulo DEPTH, plus the entry array.
- Output derivation:
  - `in_ready = (count != DEPTH) && !flush && !rst`.
  - `out_valid = (count != 0) && !rst`.
  - `out_data = mem[rd_ptr]`.
- Push, on `in_transfer`: write `mem[wr_ptr]`, increment `wr_ptr`.
- Pop, on `out_transfer`: increment `rd_ptr`.
- Count update:
  - `count` increments on push only.
  - `count` decrements on pop only.
  - `count` is unchanged on a simultaneous push and pop. When full, push is impossible, so simultaneous push/pop only occurs with 0 < count < DEPTH, or at count 0 with bypass.
- Flush takes priority over everything:
  - `count`, `wr_ptr` and `rd_ptr` go to 0 next cycle.
  - `in_ready` is low during flush, so no push occurs.
  - A pop asserted in the flush cycle still completes: the consumer receives the head, then the buffer is empty.
- `enable_transfer` low:
  - `out_valid` still reflects occupancy.
  - `out_transfer` is 0.
  - Data is held stable.
- `out_data` is stable while `out_valid && !out_transfer`. Contents of empty entries are don't-care.

## Timing
- Outputs during and immediately after reset: `in_ready`=0, `out_valid`=0, `level`=0, `in_transfer`=0, `out_transfer`=0. `out_data` is X/don't-care.
- First cycle after `rst` deasserts: `in_ready`=1.
- Latency without bypass: data pushed in cycle N is visible at `out_data` with `out_valid`=1 in cycle N+1.
- `in_ready` falls the cycle after the push that makes `count`=DEPTH. It rises the cycle after the first pop from full.
- Full throughput: with `out_ready`=`enable_transfer`=1 and count ≥1, one push and one pop per cycle are sustained indefinitely.
- Reset mid-operation: all stored entries are dropped. Any transfer in the reset cycle is suppressed.

## Configuration
- `SKID_BUFFER_BYPASS_EN` defined: when `count`==0 and not flushing:
  - `out_valid = in_valid` and `out_data = in_data`, giving zero latency.
  - If `out_transfer` occurs in that cycle, the word is not stored: `count` stays 0 and pointers are unchanged.
  - Consequence: `out_valid` and `out_data` are combinational from the input when the buffer is empty.
- Not defined: no combinational input→output path; minimum latency is 1 cycle.

## Structure
- Shared package: no typedefs.
- Local constants `PTR_W = $clog2(DEPTH)` and `LVL_W = $clog2(DEPTH+1)` are derived in-module.
- Sub-module `skid_buffer_mem`: DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port, no reset on data.
- Control (count, pointers, handshake, flush, bypass) lives in the top module.

## Test plan
- Fill, DEPTH=4: `out_ready`=0, push 0xA0..0xA3 → `level`=4, `in_ready`=0 the cycle after the 4th push. Then set `out_ready`=1 → outputs 0xA0,0xA1,0xA2,0xA3 in order; `in_ready`=1 one cycle after the first pop.
- Streaming: continuous `in_valid` and `out_ready`, 100 incrementing words → zero drops, 1-cycle latency (0 with BYPASS), `level` stays ≤1.
- Enable gate: `level`=2, `out_ready`=1, `enable_transfer`=0 for 3 cycles → `out_transfer`=0, `out_data` stable, `level`=2. Re-enable → 2 pops.
- Flush: `level`=3 with a concurrent `in_valid`, assert `flush` → next cycle `level`=0, `out_valid`=0, incoming word not accepted.
- Reset mid-stream: `rst` high while `level`=2 → `in_ready`=0 and `out_valid`=0 during reset; `level`=0 and `in_ready`=1 the cycle after release.
- Wrap-around: DEPTH=2, 7 alternating push/pop pairs with data 0x1..0x7 → read sequence equals write sequence; pointers wrap without loss.
